// File: rtl/mem_load_resp.sv
// Load-response queue: tracks accepted loads, captures in-order read data, and
// formats byte/half/word/lwl/lwr results for writeback. Flushed loads become ghosts.
module mem_load_resp #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_ea,
    input  logic [6:0]  req_ldt,
    input  logic [31:0] req_rt_data,
    input  logic [4:0]  req_dest,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    input  logic        flush,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_wdata,
    output logic        resp_err
);

    logic [1:0]  ea_q     [DEPTH];
    logic [6:0]  ldt_q    [DEPTH];
    logic [31:0] rt_q     [DEPTH];
    logic [4:0]  dest_q   [DEPTH];
    logic [31:0] rdata_q  [DEPTH];
    logic        filled_q [DEPTH];
    logic        ghost_q  [DEPTH];

    logic [PTR_W:0]   wr_q, wr_d, fill_q, fill_d, rd_q, rd_d;
    logic [PTR_W-1:0] wr_idx, fill_idx, rd_idx;
    logic             empty, full, push, fill, pop;
    logic             resp_err_q, resp_err_d;

    logic [1:0]  h_ea;
    logic [6:0]  h_ldt;
    logic [31:0] h_d, h_r, h_shift, h_lwl, h_lwr, h_fmt;
    logic [7:0]  h_byte;
    logic [15:0] h_half;

    always_comb begin
        wr_idx   = wr_q[PTR_W-1:0];
        fill_idx = fill_q[PTR_W-1:0];
        rd_idx   = rd_q[PTR_W-1:0];
        empty    = (wr_q == rd_q);
        full     = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_idx == rd_idx);
        req_ready = !full && !flush;
        push     = req_valid && req_ready;
        fill     = data_data_ok && (fill_q != wr_q);
        wb_valid = !empty && filled_q[rd_idx] && !ghost_q[rd_idx];
        // Filled ghosts drain one per cycle without reaching WB.
        pop      = !flush && !empty && filled_q[rd_idx] && (ghost_q[rd_idx] || wb_ready);
        wr_d     = wr_q + {{PTR_W{1'b0}}, push};
        fill_d   = fill_q + {{PTR_W{1'b0}}, fill};
        // Everything already filled (including this cycle's fill) is dropped on flush.
        rd_d     = flush ? fill_d : (rd_q + {{PTR_W{1'b0}}, pop});
        resp_err_d = resp_err_q || (data_data_ok && !fill);
    end

    always_comb begin
        h_ea    = ea_q[rd_idx];
        h_ldt   = ldt_q[rd_idx];
        h_d     = rdata_q[rd_idx];
        h_r     = rt_q[rd_idx];
        h_shift = h_d >> {h_ea, 3'b000};
        h_byte  = h_shift[7:0];
        h_half  = h_ea[1] ? h_d[31:16] : h_d[15:0];
        h_lwl   = h_d;
        h_lwr   = h_d;
        case (h_ea)
            2'd0: begin h_lwl = {h_d[7:0],  h_r[23:0]}; h_lwr = h_d;                      end
            2'd1: begin h_lwl = {h_d[15:0], h_r[15:0]}; h_lwr = {h_r[31:24], h_d[31:8]};  end
            2'd2: begin h_lwl = {h_d[23:0], h_r[7:0]};  h_lwr = {h_r[31:16], h_d[31:16]}; end
            default: begin h_lwl = h_d;                 h_lwr = {h_r[31:8],  h_d[31:24]}; end
        endcase
        h_fmt = ({32{h_ldt[0]}} & h_d)
              | ({32{h_ldt[1]}} & {{24{h_byte[7]}}, h_byte})
              | ({32{h_ldt[2]}} & {24'd0, h_byte})
              | ({32{h_ldt[3]}} & {{16{h_half[15]}}, h_half})
              | ({32{h_ldt[4]}} & {16'd0, h_half})
              | ({32{h_ldt[5]}} & h_lwl)
              | ({32{h_ldt[6]}} & h_lwr);
        wb_dest  = empty ? '0 : dest_q[rd_idx];
        wb_wdata = empty ? '0 : h_fmt;
        resp_err = resp_err_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q       <= '0;
            fill_q     <= '0;
            rd_q       <= '0;
            resp_err_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            fill_q     <= fill_d;
            rd_q       <= rd_d;
            resp_err_q <= resp_err_d;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ea_q[i]     <= '0;
                ldt_q[i]    <= '0;
                rt_q[i]     <= '0;
                dest_q[i]   <= '0;
                rdata_q[i]  <= '0;
                filled_q[i] <= 1'b0;
                ghost_q[i]  <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (flush) begin
                    ghost_q[i] <= 1'b1;
                end
                if (push && (wr_idx == PTR_W'(i))) begin
                    ea_q[i]     <= req_ea;
                    ldt_q[i]    <= req_ldt;
                    rt_q[i]     <= req_rt_data;
                    dest_q[i]   <= req_dest;
                    filled_q[i] <= 1'b0;
                    ghost_q[i]  <= 1'b0;
                end
                if (fill && (fill_idx == PTR_W'(i))) begin
                    rdata_q[i]  <= data_rdata;
                    filled_q[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_load_resp.sv
// Directed bench for mem_load_resp: formatting, full/hold, back-to-back, flush, resp_err, reset.
module tb_mem_load_resp;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_ea;
    logic [6:0]  req_ldt;
    logic [31:0] req_rt_data;
    logic [4:0]  req_dest;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        flush;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_dest;
    logic [31:0] wb_wdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    mem_load_resp #(.DEPTH(2), .PTR_W(1)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_ea(req_ea),
        .req_ldt(req_ldt), .req_rt_data(req_rt_data), .req_dest(req_dest),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .flush(flush),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest),
        .wb_wdata(wb_wdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    localparam int NV = 15;
    logic [6:0]  v_ldt [NV] = '{7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h01, 7'h02,
                                7'h08, 7'h20, 7'h40, 7'h00, 7'h10, 7'h20, 7'h40};
    logic [1:0]  v_ea  [NV] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd2, 2'd1,
                                2'd3, 2'd0, 2'd3, 2'd0, 2'd1, 2'd2, 2'd2};
    logic [31:0] v_d   [NV] = '{32'h80FF_0000, 32'h80FF_0000, 32'h8001_1234, 32'h8001_1234,
                                32'hAABB_CCDD, 32'hAABB_CCDD, 32'hDEAD_BEEF, 32'h0000_7F00,
                                32'h1234_5678, 32'hAABB_CCDD, 32'hAABB_CCDD, 32'hFFFF_FFFF,
                                32'h1234_ABCD, 32'hAABB_CCDD, 32'hAABB_CCDD};
    logic [31:0] v_exp [NV] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001,
                                32'hCCDD_3344, 32'h11AA_BBCC, 32'hDEAD_BEEF, 32'h0000_007F,
                                32'h0000_1234, 32'hDD22_3344, 32'h1122_33AA, 32'h0000_0000,
                                32'h0000_ABCD, 32'hBBCC_DD44, 32'h1122_AABB};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [1:0] ea, input logic [6:0] ldt,
                            input logic [31:0] rt, input logic [4:0] dest);
        req_valid = 1'b1; req_ea = ea; req_ldt = ldt; req_rt_data = rt; req_dest = dest;
        cyc();
        req_valid = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d);
        data_data_ok = 1'b1; data_rdata = d;
        cyc();
        data_data_ok = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; req_valid = 1'b0; req_ea = '0; req_ldt = '0; req_rt_data = '0;
        req_dest = '0; data_data_ok = 1'b0; data_rdata = '0; flush = 1'b0; wb_ready = 1'b0;
        cyc(); cyc();
        resetn = 1'b1;
        #1;
        total++;
        if ({wb_valid, wb_dest, wb_wdata, req_ready, resp_err} !== {1'b0, 5'd0, 32'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got v=%b d=%0d w=%h rdy=%b err=%b, want v=0 d=0 w=0 rdy=1 err=0",
                     wb_valid, wb_dest, wb_wdata, req_ready, resp_err);
        end
    endtask

    task automatic test_format();
        for (int i = 0; i < NV; i++) begin
            push_req(v_ea[i], v_ldt[i], 32'h1122_3344, 5'(i + 1));
            resp(v_d[i]);
            total++;
            if (wb_valid !== 1'b1 || wb_wdata !== v_exp[i] || wb_dest !== 5'(i + 1)) begin
                bad++;
                $display("FAIL format[%0d]: got v=%b w=%h d=%0d, want v=1 w=%h d=%0d",
                         i, wb_valid, wb_wdata, wb_dest, v_exp[i], i + 1);
            end
            wb_ready = 1'b1;
            cyc();
            wb_ready = 1'b0;
            total++;
            if (wb_valid !== 1'b0 || wb_wdata !== 32'd0) begin
                bad++;
                $display("FAIL format_pop[%0d]: got v=%b w=%h, want v=0 w=0", i, wb_valid, wb_wdata);
            end
        end
    endtask

    task automatic test_full_hold();
        push_req(2'd0, 7'h01, 32'h0, 5'd1);
        push_req(2'd0, 7'h01, 32'h0, 5'd2);
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_ready: got %b want 0", req_ready);
        end
        resp(32'hA1A1_A1A1);
        resp(32'hB2B2_B2B2);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (wb_valid !== 1'b1 || wb_wdata !== 32'hA1A1_A1A1 || wb_dest !== 5'd1) begin
                bad++;
                $display("FAIL hold[%0d]: got v=%b w=%h d=%0d, want v=1 w=a1a1a1a1 d=1",
                         k, wb_valid, wb_wdata, wb_dest);
            end
            cyc();
        end
        wb_ready = 1'b1;
        req_valid = 1'b1; req_ea = '0; req_ldt = 7'h01; req_dest = 5'd9;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL full_pop_ready: got %b want 0", req_ready);
        end
        cyc();
        req_valid = 1'b0;
        total++;
        if (wb_valid !== 1'b1 || wb_wdata !== 32'hB2B2_B2B2 || wb_dest !== 5'd2) begin
            bad++;
            $display("FAIL order_second: got v=%b w=%h d=%0d, want v=1 w=b2b2b2b2 d=2",
                     wb_valid, wb_wdata, wb_dest);
        end
        cyc();
        wb_ready = 1'b0;
        total++;
        if (wb_valid !== 1'b0 || wb_dest !== 5'd0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL drained: got v=%b d=%0d rdy=%b, want v=0 d=0 rdy=1",
                     wb_valid, wb_dest, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        push_req(2'd0, 7'h04, 32'h0, 5'd5);
        req_valid = 1'b1; req_ea = 2'd1; req_ldt = 7'h04; req_dest = 5'd6;
        data_data_ok = 1'b1; data_rdata = 32'h0000_0011;
        cyc();
        req_valid = 1'b0;
        data_rdata = 32'h0000_2200;
        wb_ready = 1'b1;
        #1;
        total++;
        if (wb_valid !== 1'b1 || wb_wdata !== 32'h11 || wb_dest !== 5'd5) begin
            bad++;
            $display("FAIL b2b_first: got v=%b w=%h d=%0d, want v=1 w=11 d=5", wb_valid, wb_wdata, wb_dest);
        end
        cyc();
        data_data_ok = 1'b0;
        total++;
        if (wb_valid !== 1'b1 || wb_wdata !== 32'h22 || wb_dest !== 5'd6) begin
            bad++;
            $display("FAIL b2b_second: got v=%b w=%h d=%0d, want v=1 w=22 d=6", wb_valid, wb_wdata, wb_dest);
        end
        cyc();
        wb_ready = 1'b0;
        total++;
        if (wb_valid !== 1'b0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: got v=%b err=%b, want v=0 err=0", wb_valid, resp_err);
        end
    endtask

    task automatic test_flush();
        push_req(2'd0, 7'h01, 32'h0, 5'd3);
        push_req(2'd0, 7'h01, 32'h0, 5'd4);
        resp(32'h3333_3333);
        flush = 1'b1; req_valid = 1'b1; req_dest = 5'd12; req_ldt = 7'h01;
        #1;
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL flush_ready: got %b want 0", req_ready);
        end
        cyc();
        flush = 1'b0; req_valid = 1'b0;
        total++;
        if (wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_valid: got %b want 0", wb_valid);
        end
        resp(32'h4444_4444);
        total++;
        if (wb_valid !== 1'b0 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL ghost_absorb: got v=%b err=%b, want v=0 err=0", wb_valid, resp_err);
        end
        cyc();
        total++;
        if (wb_valid !== 1'b0 || wb_dest !== 5'd0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_empty: got v=%b d=%0d rdy=%b, want v=0 d=0 rdy=1",
                     wb_valid, wb_dest, req_ready);
        end
        // Fill arriving in the flush cycle itself.
        push_req(2'd0, 7'h01, 32'h0, 5'd7);
        push_req(2'd0, 7'h01, 32'h0, 5'd8);
        flush = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h7777_7777;
        cyc();
        flush = 1'b0; data_data_ok = 1'b0;
        total++;
        if (wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_fill_same: got v=%b want 0", wb_valid);
        end
        resp(32'h8888_8888);
        cyc();
        push_req(2'd0, 7'h01, 32'h0, 5'd10);
        resp(32'h1010_1010);
        total++;
        if (wb_valid !== 1'b1 || wb_wdata !== 32'h1010_1010 || wb_dest !== 5'd10 || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL post_flush_load: got v=%b w=%h d=%0d err=%b, want v=1 w=10101010 d=10 err=0",
                     wb_valid, wb_wdata, wb_dest, resp_err);
        end
        wb_ready = 1'b1;
        cyc();
        wb_ready = 1'b0;
    endtask

    task automatic test_resp_err_reset();
        resp(32'hDEAD_0000);
        total++;
        if (resp_err !== 1'b1) begin
            bad++;
            $display("FAIL resp_err_set: got %b want 1", resp_err);
        end
        push_req(2'd0, 7'h01, 32'h0, 5'd11);
        resp(32'h5555_AAAA);
        total++;
        if (resp_err !== 1'b1 || wb_valid !== 1'b1 || wb_wdata !== 32'h5555_AAAA) begin
            bad++;
            $display("FAIL resp_err_sticky: got err=%b v=%b w=%h, want err=1 v=1 w=5555aaaa",
                     resp_err, wb_valid, wb_wdata);
        end
        resetn = 1'b0;
        #1;
        total++;
        if ({wb_valid, wb_dest, wb_wdata, resp_err} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            bad++;
            $display("FAIL mid_reset: got v=%b d=%0d w=%h err=%b, want all 0",
                     wb_valid, wb_dest, wb_wdata, resp_err);
        end
        cyc();
        resetn = 1'b1;
        resp(32'h1);
        total++;
        if (resp_err !== 1'b1 || wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL resp_after_reset: got err=%b v=%b, want err=1 v=0", resp_err, wb_valid);
        end
    endtask

    initial begin
        test_reset();
        test_format();
        test_full_hold();
        test_back_to_back();
        test_flush();
        test_resp_err_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_load_resp.md
Name: mem_load_resp

Overview:
- Load-response side of the data SRAM-like interface; counterpart to the store-side write formatter in EX.
- Queues one descriptor per load whose address handshake has completed, captures the in-order `data_rdata` responses, and applies byte/half extraction, sign/zero extension and lwl/lwr merge with the old rt value.
- Presents finished results to WB through a valid/ready handshake.
- Absorbs responses for loads cancelled by an exception flush.

Parameters:
- DEPTH, 2, max outstanding loads; power of 2, ≥2.
- PTR_W, 1, log2(DEPTH).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  load descriptor offered (address accepted by memory this cycle).
- req_ready  out  1  descriptor queue can accept.
- req_ea  in  2  alu_result[1:0] of the load.
- req_ldt  in  7  one-hot load type: [0]lw [1]lb [2]lbu [3]lh [4]lhu [5]lwl [6]lwr.
- req_rt_data  in  32  old rt value (lwl/lwr merge).
- req_dest  in  5  destination register.
- data_data_ok  in  1  read data returned this cycle.
- data_rdata  in  32  returned word (word-aligned address).
- flush  in  1  cancel all queued loads.
- wb_valid  out  1  head result available.
- wb_ready  in  1  WB consumes.
- wb_dest  out  5  destination register.
- wb_wdata  out  32  formatted load result.
- resp_err  out  1  sticky: response with no unfilled live/ghost entry.

Behaviour:
- Reset (async, resetn=0): queue empty, all pointers 0, all entry flags 0, resp_err=0. While the queue is empty: wb_valid=0, wb_dest=0, wb_wdata=0.
- Entry fields: ea, ldt, rt_data, dest, rdata, filled, ghost.
- Pointers:
  - wr_ptr: push.
  - fill_ptr: next entry awaiting data.
  - rd_ptr: pop.
  - Each pointer is PTR_W+1 bits, wraps modulo 2*DEPTH; full/empty compare MSBs.
- req_ready = !full & !flush. Push when req_valid & req_ready: entry written, filled=0, ghost=0.
- Response:
  - On data_data_ok, if fill_ptr != wr_ptr: entry[fill_ptr].rdata=data_rdata, filled=1, fill_ptr++.
  - Otherwise the response is dropped and resp_err is set (stays 1 until reset).
- Pop rules:
  - wb_valid = !empty & head.filled & !head.ghost.
  - Pop on wb_valid & wb_ready.
  - A head that is both filled and ghost pops automatically with no WB output, one per cycle.
- Latency: data_data_ok in cycle N for the head entry gives wb_valid=1 in cycle N+1. Outputs come combinationally from registered entry state. Back-to-back responses sustain 1 result/cycle with wb_ready=1.
- Output stability: while wb_valid=1 & wb_ready=0, wb_dest and wb_wdata are held stable.
- Flush (synchronous, takes priority):
  - Filled live entries are discarded: rd_ptr advances past them.
  - Unfilled entries become ghost. They keep their slot until their response arrives, then pop silently.
  - A push in the flush cycle is blocked.
  - A data_data_ok in the flush cycle fills its entry, which is then treated as discarded.
  - wb_valid=0 in the cycle after flush unless a new live entry is filled.
- Formatting (e = ea, d = rdata, r = rt_data):
  - lw: d.
  - lb/lbu: byte d[8e+7:8e], sign-/zero-extended.
  - lh/lhu: half selected by e[1] only (e[0] ignored), sign-/zero-extended.
  - lwl:
    - e=0: {d[7:0],r[23:0]}
    - e=1: {d[15:0],r[15:0]}
    - e=2: {d[23:0],r[7:0]}
    - e=3: d
  - lwr:
    - e=0: d
    - e=1: {r[31:24],d[31:8]}
    - e=2: {r[31:16],d[31:16]}
    - e=3: {r[31:8],d[31:24]}
  - AND-OR select over ldt; ldt=0 gives wdata 0.
- Simultaneous push, fill and pop in one cycle are all legal. Full with pop in the same cycle still reports req_ready=0 (no pass-through).
- Reset mid-operation clears everything; responses arriving after reset with no entries set resp_err.

Test Plan:
- lb, ea=3, rdata=0x80FF_0000 → wb_wdata=0xFFFF_FF80. Same with lbu → 0x0000_0080.
- lh, ea=2, rdata=0x8001_1234 → 0xFFFF_8001. lhu → 0x0000_8001.
- lwl, ea=1, rdata=0xAABB_CCDD, rt=0x1122_3344 → 0xCCDD_3344. lwr, ea=1 → 0x11AA_BBCC.
- DEPTH=2:
  - Push 2 → req_ready=0.
  - Data_ok on consecutive cycles with wb_ready=0 for 3 cycles → first result held stable.
  - Release wb_ready → results in push order, 1/cycle.
- Push 2 loads, fill 1, flush:
  - No wb_valid afterward.
  - Second data_ok is absorbed silently.
  - Queue empty next cycle, resp_err=0.
- data_data_ok with empty queue → resp_err=1, sticky through later normal loads. resetn pulse mid-queue → all outputs 0 immediately.
